// File: rtl/modbus_scan_pkg.sv
// -----------------------------------------------------------------------------
// modbus_scan_pkg
// Shared definitions for the Modbus master-mode poll scheduler:
//   - scheduler state encoding
//   - counter / index widths
//   - Modbus function codes shared with modbus_controller
//   - scan-count clamp helper
// -----------------------------------------------------------------------------
package modbus_scan_pkg;

    localparam int CNT_W = 16;
    localparam int IDX_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_RSP = 3'd3,
        ST_PERIOD   = 3'd4
    } scan_state_t;

    // Function codes understood by the frame engine
    localparam logic [7:0] FC_READ_COILS          = 8'h01;
    localparam logic [7:0] FC_READ_DISCRETE       = 8'h02;
    localparam logic [7:0] FC_READ_HOLDING        = 8'h03;
    localparam logic [7:0] FC_READ_INPUT          = 8'h04;
    localparam logic [7:0] FC_WRITE_SINGLE_COIL   = 8'h05;
    localparam logic [7:0] FC_WRITE_SINGLE_REG    = 8'h06;
    localparam logic [7:0] FC_WRITE_MULTI_COILS   = 8'h0F;
    localparam logic [7:0] FC_WRITE_MULTI_REGS    = 8'h10;

    // Limit the CSR entry count to the physical table depth
    function automatic logic [IDX_W-1:0] clamp_count(input logic [IDX_W-1:0] cnt,
                                                     input logic [IDX_W-1:0] max_cnt);
        return (cnt > max_cnt) ? max_cnt : cnt;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// -----------------------------------------------------------------------------
// ms_tick_gen
// Free-running millisecond prescaler. Counts 0..TICKS_PER_MS-1 and raises
// tick for one clock while the count sits at its terminal value.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous reset, active high
//   clr   in  restart the prescaler from 0 (aligned with a ms timer clear)
//   tick  out one-cycle millisecond pulse (registered)
// -----------------------------------------------------------------------------
module ms_tick_gen #(
    parameter int TICKS_PER_MS = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [CW-1:0] LAST_C = CW'(TICKS_PER_MS - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          tick_r;

    // Next prescaler value: clear has priority over wrap and increment
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = {CW{1'b0}};
        end else if (cnt_r == LAST_C) begin
            cnt_nxt_s = {CW{1'b0}};
        end else begin
            cnt_nxt_s = cnt_r + CW'(1);
        end
    end

    // Prescaler register; tick is registered so it is high exactly while cnt_r is terminal
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            tick_r <= (cnt_nxt_s == LAST_C);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/modbus_scan_scheduler.sv
// -----------------------------------------------------------------------------
// modbus_scan_scheduler
// Master-mode poll sequencer. Walks the CSR scan table, issues one request per
// entry to the frame engine, waits for a response or a per-attempt timeout,
// retries failed entries, counts failures and completed passes and idles
// scan_period_ms between passes.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   scan_en, scan_count,
//   scan_retry_max, scan_period_ms scan configuration from the CSR block
//   stats_clr                     pulse: zero scan_cycles_done / scan_err_count
//   scan_idx                      table read index; scan_slave/func/start_addr/qty
//                                 return the entry one cycle later
//   req_valid/req_ready, req_*    request handshake and latched entry fields
//   rsp_done, rsp_ok              response completion pulse and its status
//   busy                          scheduler not in IDLE
//   scan_cycles_done              completed passes (wrapping)
//   scan_err_count                entries failed after all retries (saturating)
//   scan_err_map                  per-entry failure flags, only when the
//                                 SCAN_ERR_MAP_EN macro is defined
// -----------------------------------------------------------------------------
module modbus_scan_scheduler
    import modbus_scan_pkg::*;
#(
    parameter int SCAN_MAX        = 16,
    parameter int TICKS_PER_MS    = 50000,
    parameter int RESP_TIMEOUT_MS = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_en,
    input  logic [IDX_W-1:0]  scan_count,
    input  logic [3:0]        scan_retry_max,
    input  logic [CNT_W-1:0]  scan_period_ms,
    input  logic              stats_clr,
    output logic [IDX_W-1:0]  scan_idx,
    input  logic [7:0]        scan_slave,
    input  logic [7:0]        scan_func,
    input  logic [15:0]       scan_start_addr,
    input  logic [15:0]       scan_qty,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [7:0]        req_slave,
    output logic [7:0]        req_func,
    output logic [15:0]       req_addr,
    output logic [15:0]       req_qty,
    input  logic              rsp_done,
    input  logic              rsp_ok,
    output logic              busy,
    output logic [CNT_W-1:0]  scan_cycles_done,
    output logic [CNT_W-1:0]  scan_err_count
`ifdef SCAN_ERR_MAP_EN
    ,
    output logic [SCAN_MAX-1:0] scan_err_map
`endif
);

    localparam logic [IDX_W-1:0] SCAN_MAX_C = IDX_W'(SCAN_MAX);
    localparam logic [CNT_W:0]   RESP_TO_C  = (CNT_W+1)'(RESP_TIMEOUT_MS);

    scan_state_t       state_r, state_nxt_s, adv_state_s;
    logic [IDX_W-1:0]  scan_idx_r, count_c_s;
    logic [3:0]        retry_r;
    logic [CNT_W-1:0]  ms_timer_r, cycles_r, err_r;
    logic [CNT_W:0]    timer_inc_s;
    logic              req_valid_r, busy_r;
    logic [7:0]        req_slave_r, req_func_r;
    logic [15:0]       req_addr_r, req_qty_r;
    logic              tick_s, last_s, timeout_s, period_hit_s;
    logic              latch_s, retry_clr_s, retry_inc_s, issue_clr_s, idx_zero_s;
    logic              advance_s, err_inc_s, map_set_s, map_clr_s;
    logic              cyc_inc_s, idx_inc_s, timer_clr_s;

    ms_tick_gen #(.TICKS_PER_MS(TICKS_PER_MS)) u_ms_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr_s),
        .tick (tick_s)
    );

    assign count_c_s = clamp_count(scan_count, SCAN_MAX_C);
    // A count that shrank below the current index (or to zero) ends the pass here
    assign last_s = (count_c_s == 8'd0) || (scan_idx_r >= (count_c_s - 8'd1));
    // One bit wider so the compare cannot wrap at 16'hFFFF
    assign timer_inc_s  = {1'b0, ms_timer_r} + 17'd1;
    assign timeout_s    = tick_s && (timer_inc_s >= RESP_TO_C);
    assign period_hit_s = (scan_period_ms == 16'd0) ||
                          (tick_s && (timer_inc_s >= {1'b0, scan_period_ms}));
    assign adv_state_s  = !scan_en ? ST_IDLE : (last_s ? ST_PERIOD : ST_FETCH);
    assign cyc_inc_s    = advance_s && last_s;
    assign idx_inc_s    = advance_s && !last_s;
    assign timer_clr_s  = issue_clr_s || cyc_inc_s;

    // Next-state and control strobes
    always_comb begin
        state_nxt_s = state_r;
        latch_s     = 1'b0;
        retry_clr_s = 1'b0;
        retry_inc_s = 1'b0;
        issue_clr_s = 1'b0;
        idx_zero_s  = 1'b0;
        advance_s   = 1'b0;
        err_inc_s   = 1'b0;
        map_set_s   = 1'b0;
        map_clr_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (scan_en && (count_c_s != 8'd0)) begin
                    idx_zero_s  = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (scan_en) begin
                    latch_s     = 1'b1;
                    retry_clr_s = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // Request is never withdrawn, even with scan_en low
                if (req_ready) begin
                    issue_clr_s = 1'b1;
                    state_nxt_s = ST_WAIT_RSP;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT_RSP: begin
                // A response in the timeout cycle takes precedence over the timeout
                if (rsp_done && rsp_ok) begin
                    map_clr_s   = 1'b1;
                    advance_s   = 1'b1;
                    state_nxt_s = adv_state_s;
                end else if (rsp_done || timeout_s) begin
                    if (retry_r >= scan_retry_max) begin
                        err_inc_s   = 1'b1;
                        map_set_s   = 1'b1;
                        advance_s   = 1'b1;
                        state_nxt_s = adv_state_s;
                    end else if (scan_en) begin
                        retry_inc_s = 1'b1;
                        state_nxt_s = ST_ISSUE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_RSP;
                end
            end
            ST_PERIOD: begin
                if (!scan_en) begin
                    state_nxt_s = ST_IDLE;
                end else if (period_hit_s) begin
                    idx_zero_s  = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_PERIOD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request interface, index, retry count and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            req_slave_r <= 8'd0;
            req_func_r  <= 8'd0;
            req_addr_r  <= 16'd0;
            req_qty_r   <= 16'd0;
            scan_idx_r  <= 8'd0;
            retry_r     <= 4'd0;
        end else begin
            req_valid_r <= (state_nxt_s == ST_ISSUE);
            busy_r      <= (state_nxt_s != ST_IDLE);
            if (latch_s) begin
                req_slave_r <= scan_slave;
                req_func_r  <= scan_func;
                req_addr_r  <= scan_start_addr;
                req_qty_r   <= scan_qty;
            end
            if (idx_zero_s) begin
                scan_idx_r <= 8'd0;
            end else if (idx_inc_s) begin
                scan_idx_r <= scan_idx_r + 8'd1;
            end
            if (retry_clr_s) begin
                retry_r <= 4'd0;
            end else if (retry_inc_s) begin
                retry_r <= retry_r + 4'd1;
            end
        end
    end

    // Millisecond timer shared by the response timeout and the inter-pass gap
    always_ff @(posedge clk) begin
        if (rst) begin
            ms_timer_r <= 16'd0;
        end else if (timer_clr_s) begin
            ms_timer_r <= 16'd0;
        end else if (tick_s && ((state_r == ST_WAIT_RSP) || (state_r == ST_PERIOD))) begin
            ms_timer_r <= ms_timer_r + 16'd1;
        end
    end

    // Statistics counters; stats_clr beats a simultaneous increment
    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_r <= 16'd0;
            err_r    <= 16'd0;
        end else if (stats_clr) begin
            cycles_r <= 16'd0;
            err_r    <= 16'd0;
        end else begin
            if (cyc_inc_s) begin
                cycles_r <= cycles_r + 16'd1;
            end
            if (err_inc_s && (err_r != 16'hFFFF)) begin
                err_r <= err_r + 16'd1;
            end
        end
    end

`ifdef SCAN_ERR_MAP_EN
    logic [SCAN_MAX-1:0] err_map_r;

    // Per-entry failure flags: set on final failure, cleared on success
    always_ff @(posedge clk) begin
        if (rst) begin
            err_map_r <= {SCAN_MAX{1'b0}};
        end else if (stats_clr) begin
            err_map_r <= {SCAN_MAX{1'b0}};
        end else begin
            for (int i = 0; i < SCAN_MAX; i++) begin
                if (scan_idx_r == IDX_W'(i)) begin
                    if (map_set_s) begin
                        err_map_r[i] <= 1'b1;
                    end else if (map_clr_s) begin
                        err_map_r[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign scan_err_map = err_map_r;
`else
    logic map_unused_s;
    assign map_unused_s = map_set_s ^ map_clr_s;
`endif

    assign scan_idx         = scan_idx_r;
    assign req_valid        = req_valid_r;
    assign req_slave        = req_slave_r;
    assign req_func         = req_func_r;
    assign req_addr         = req_addr_r;
    assign req_qty          = req_qty_r;
    assign busy             = busy_r;
    assign scan_cycles_done = cycles_r;
    assign scan_err_count   = err_r;

endmodule

// File: tb/tb_modbus_scan_scheduler.sv
// -----------------------------------------------------------------------------
// tb_modbus_scan_scheduler
// Directed, table-driven bench for modbus_scan_scheduler with
// TICKS_PER_MS=10 and RESP_TIMEOUT_MS=3. Optional SCAN_ERR_MAP_EN checks are
// compiled in when the macro is defined.
// -----------------------------------------------------------------------------
module tb_modbus_scan_scheduler;

    logic        clk = 1'b0;
    logic        rst, scan_en, stats_clr, req_ready, rsp_done, rsp_ok;
    logic [7:0]  scan_count;
    logic [3:0]  scan_retry_max;
    logic [15:0] scan_period_ms;
    logic [7:0]  scan_idx, scan_slave, scan_func;
    logic [15:0] scan_start_addr, scan_qty;
    logic        req_valid, busy;
    logic [7:0]  req_slave, req_func;
    logic [15:0] req_addr, req_qty, scan_cycles_done, scan_err_count;
`ifdef SCAN_ERR_MAP_EN
    logic [15:0] scan_err_map;
`endif

    modbus_scan_scheduler #(
        .SCAN_MAX(16), .TICKS_PER_MS(10), .RESP_TIMEOUT_MS(3)
    ) dut (
        .clk(clk), .rst(rst), .scan_en(scan_en), .scan_count(scan_count),
        .scan_retry_max(scan_retry_max), .scan_period_ms(scan_period_ms),
        .stats_clr(stats_clr), .scan_idx(scan_idx), .scan_slave(scan_slave),
        .scan_func(scan_func), .scan_start_addr(scan_start_addr), .scan_qty(scan_qty),
        .req_valid(req_valid), .req_ready(req_ready), .req_slave(req_slave),
        .req_func(req_func), .req_addr(req_addr), .req_qty(req_qty),
        .rsp_done(rsp_done), .rsp_ok(rsp_ok), .busy(busy),
        .scan_cycles_done(scan_cycles_done), .scan_err_count(scan_err_count)
`ifdef SCAN_ERR_MAP_EN
        , .scan_err_map(scan_err_map)
`endif
    );

    always #5 clk = ~clk;

    // Scan table as seen by the CSR block: entry fields derived from the index
    always_comb begin
        scan_slave      = 8'h10 + scan_idx;
        scan_func       = scan_idx[0] ? 8'h04 : 8'h03;
        scan_start_addr = {scan_idx, 8'h20};
        scan_qty        = {8'h00, scan_idx} + 16'd1;
    end

    typedef struct {
        int count;
        int retry_max;
        int period;
        int n_req;
        int ok_mask;
        bit no_rsp;
        int exp_err;
        int exp_cyc;
        bit exp_map0;
    } vec_t;

    vec_t vecs[5];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] exp_fields(input int idx);
        logic [7:0] i8;
        i8 = 8'(idx);
        return {8'h10 + i8, (i8[0] ? 8'h04 : 8'h03), {i8, 8'h20}, {8'h00, i8} + 16'd1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!req_valid && n < 300) begin
            step();
            n++;
        end
        if (!req_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_req: req_valid still 0 after %0d cycles, expected 1", n);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        check("idle_reached", {63'd0, busy}, 64'd0);
    endtask

    task automatic configure(input int cnt, input int rmax, input int per);
        scan_count     = 8'(cnt);
        scan_retry_max = 4'(rmax);
        scan_period_ms = 16'(per);
        stats_clr      = 1'b1;
        step();
        stats_clr      = 1'b0;
        check("stats_clr_cycles", {48'd0, scan_cycles_done}, 64'd0);
        check("stats_clr_errors", {48'd0, scan_err_count}, 64'd0);
    endtask

    task automatic accept();
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        check("accept_drops_valid", {63'd0, req_valid}, 64'd0);
    endtask

    task automatic respond_after_accept(input logic ok);
        for (int k = 0; k < 4; k++) step();
        rsp_done = 1'b1;
        rsp_ok   = ok;
        step();
        rsp_done = 1'b0;
        rsp_ok   = 1'b0;
    endtask

    // Drop scan_en with a request pending, complete it, expect IDLE
    task automatic drain();
        int n;
        scan_en = 1'b0;
        wait_req(n);
        accept();
        respond_after_accept(1'b1);
        step();
        wait_idle();
    endtask

    initial begin
        int   lat, n, m_idx, m_retry, c, base, post;
        logic ok, seen;

        // count, retry_max, period, n_req, ok_mask, no_rsp, exp_err, exp_cyc, exp_map0
        vecs[0] = '{3,  0, 0, 3,  7,           1'b0, 0, 1, 1'b0};
        vecs[1] = '{1,  2, 0, 3,  0,           1'b1, 1, 1, 1'b1};
        vecs[2] = '{1,  1, 0, 2,  2,           1'b0, 0, 1, 1'b0};
        vecs[3] = '{2,  0, 2, 2,  3,           1'b0, 0, 1, 1'b0};
        vecs[4] = '{20, 0, 0, 16, 32'h0000FFFF, 1'b0, 0, 1, 1'b0};

        rst = 1'b1; scan_en = 1'b0; stats_clr = 1'b0; req_ready = 1'b0;
        rsp_done = 1'b0; rsp_ok = 1'b0; scan_count = 8'd0;
        scan_retry_max = 4'd0; scan_period_ms = 16'd0;
        step(); step(); step();
        check("reset_req_valid", {63'd0, req_valid}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_scan_idx", {56'd0, scan_idx}, 64'd0);
        check("reset_req_fields", {16'd0, req_slave, req_func, req_addr, req_qty}, 64'd0);
        check("reset_counters", {32'd0, scan_cycles_done, scan_err_count}, 64'd0);
        rst = 1'b0;
        step();

        // Empty table: nothing is scanned
        configure(0, 0, 0);
        scan_en = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check("count0_idle", {62'd0, busy, req_valid}, 64'd0);
        scan_en = 1'b0;
        step();

        // Table-driven scans with a reference model of index/retry/latency
        for (int r = 0; r < 5; r++) begin
            configure(vecs[r].count, vecs[r].retry_max, vecs[r].period);
            scan_en = 1'b1;
            wait_req(lat);
            check("req_valid_rise_latency", 64'(lat), 64'd2);
            m_idx = 0; m_retry = 0;
            c = (vecs[r].count > 16) ? 16 : vecs[r].count;
            for (int j = 0; j < vecs[r].n_req; j++) begin
                check("req_fields", {16'd0, req_slave, req_func, req_addr, req_qty},
                      {16'd0, exp_fields(m_idx)});
                accept();
                ok   = !vecs[r].no_rsp && vecs[r].ok_mask[j];
                base = vecs[r].no_rsp ? 30 : 5;
                if (!ok && (m_retry < vecs[r].retry_max)) begin
                    m_retry++;
                    post = 0;
                end else begin
                    m_retry = 0;
                    if (m_idx >= c - 1) begin
                        m_idx = 0;
                        post  = (vecs[r].period == 0) ? 2 : 10 * vecs[r].period + 1;
                    end else begin
                        m_idx++;
                        post = 1;
                    end
                end
                n = 0;
                while (n < 400) begin
                    if (!vecs[r].no_rsp && n == 4) begin
                        rsp_done = 1'b1;
                        rsp_ok   = vecs[r].ok_mask[j];
                    end
                    step();
                    n++;
                    rsp_done = 1'b0;
                    rsp_ok   = 1'b0;
                    if (req_valid) break;
                end
                check("next_req_latency", 64'(n), 64'(base + post));
            end
            check("next_pass_fields", {16'd0, req_slave, req_func, req_addr, req_qty},
                  {16'd0, exp_fields(m_idx)});
            check("scan_idx_after", {56'd0, scan_idx}, 64'(m_idx));
            check("err_count", {48'd0, scan_err_count}, 64'(vecs[r].exp_err));
            check("cycles_done", {48'd0, scan_cycles_done}, 64'(vecs[r].exp_cyc));
`ifdef SCAN_ERR_MAP_EN
            check("err_map0", {63'd0, scan_err_map[0]}, {63'd0, vecs[r].exp_map0});
`endif
            drain();
        end

        // Back-pressure: request and fields held while req_ready is low
        configure(1, 0, 0);
        scan_en = 1'b1;
        wait_req(lat);
        for (int k = 0; k < 20; k++) begin
            check("hold_valid_fields", {15'd0, req_valid, req_slave, req_func, req_addr, req_qty},
                  {15'd0, 1'b1, exp_fields(0)});
            step();
        end
        accept();
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            seen = seen | req_valid;
        end
        check("single_accept", {63'd0, seen}, 64'd0);
        scan_en = 1'b0;
        wait_idle();

        // scan_en dropped while waiting for the response
        configure(2, 0, 0);
        scan_en = 1'b1;
        wait_req(lat);
        accept();
        step(); step();
        scan_en = 1'b0;
        step(); step();
        rsp_done = 1'b1;
        rsp_ok   = 1'b1;
        step();
        rsp_done = 1'b0;
        rsp_ok   = 1'b0;
        check("abort_wait_idle", {62'd0, busy, req_valid}, 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            seen = seen | req_valid;
        end
        check("abort_wait_no_req", {63'd0, seen}, 64'd0);

        // scan_en dropped during the inter-pass gap
        configure(1, 0, 5);
        scan_en = 1'b1;
        wait_req(lat);
        accept();
        respond_after_accept(1'b1);
        check("period_busy", {63'd0, busy}, 64'd1);
        check("period_cycles", {48'd0, scan_cycles_done}, 64'd1);
        scan_en = 1'b0;
        step();
        check("period_abort_idle", {63'd0, busy}, 64'd0);

        // stats_clr coincides with error and pass increments
        configure(1, 0, 0);
        scan_en = 1'b1;
        wait_req(lat);
        accept();
        for (int k = 0; k < 4; k++) step();
        rsp_done  = 1'b1;
        rsp_ok    = 1'b0;
        stats_clr = 1'b1;
        step();
        rsp_done  = 1'b0;
        stats_clr = 1'b0;
        check("clr_wins_err", {48'd0, scan_err_count}, 64'd0);
        check("clr_wins_cycles", {48'd0, scan_cycles_done}, 64'd0);
`ifdef SCAN_ERR_MAP_EN
        check("clr_wins_map", {48'd0, scan_err_map}, 64'd0);
`endif
        scan_en = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
